// File: rtl/branch_pred_unit.sv
// rtl/branch_pred_unit.sv - direct-mapped BTB with 2-bit counters; BPU_GSHARE_EN selects gshare counter indexing
module branch_pred_unit #(
    parameter int AWIDTH  = 32,
    parameter int ENTRIES = 16,
    parameter int CNTW    = 32,
    localparam int IDXW   = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] pc_f,
    input  logic              br_f,
    output logic              pred_taken,
    output logic [AWIDTH-1:0] pred_target,
    output logic [IDXW-1:0]   pred_cidx,
    input  logic              upd_valid,
    input  logic [AWIDTH-1:0] upd_pc,
    input  logic [IDXW-1:0]   upd_cidx,
    input  logic              upd_taken,
    input  logic [AWIDTH-1:0] upd_target,
    input  logic              upd_pred_taken,
    output logic              mispredict,
    output logic [CNTW-1:0]   lookup_cnt,
    output logic [CNTW-1:0]   mispred_cnt
);
    localparam int TAGW = AWIDTH - IDXW - 2;

    logic [ENTRIES-1:0] valid;
    logic [TAGW-1:0]    tag_mem [ENTRIES];
    logic [AWIDTH-1:0]  tgt_mem [ENTRIES];
    logic [1:0]         cnt     [ENTRIES];

    logic [IDXW-1:0] f_idx;
    logic [TAGW-1:0] f_tag;
    logic            f_hit;
    logic [IDXW-1:0] u_idx;
    logic [TAGW-1:0] u_tag;
    logic            u_hit;
    logic            tgt_mismatch;

    // Word-aligned PCs: the two low bits never select anything
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_f[1:0], upd_pc[1:0]};

    assign f_idx = pc_f[IDXW+1:2];
    assign f_tag = pc_f[AWIDTH-1:IDXW+2];
    assign u_idx = upd_pc[IDXW+1:2];
    assign u_tag = upd_pc[AWIDTH-1:IDXW+2];

`ifdef BPU_GSHARE_EN
    logic [IDXW-1:0] ghr;

    assign pred_cidx = f_idx ^ ghr;

    // Global history shifts in every resolved outcome
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr <= '0;
        end else if (upd_valid) begin
            ghr <= {ghr[IDXW-2:0], upd_taken};
        end
    end
`else
    assign pred_cidx = f_idx;
`endif

    // Lookup reads pre-update state; writes land only at the clock edge
    always_comb begin
        f_hit        = valid[f_idx] && (tag_mem[f_idx] == f_tag);
        pred_taken   = br_f && f_hit && cnt[pred_cidx][1];
        pred_target  = tgt_mem[f_idx];
        u_hit        = valid[u_idx] && (tag_mem[u_idx] == u_tag);
        tgt_mismatch = !u_hit || (tgt_mem[u_idx] != upd_target);
        mispredict   = upd_valid && ((upd_taken != upd_pred_taken) ||
                                     (upd_taken && upd_pred_taken && tgt_mismatch));
    end

    // Valid bits and saturating counters; counters restart at weak-not-taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                cnt[i] <= 2'b01;
            end
        end else if (upd_valid) begin
            if (upd_taken) begin
                valid[u_idx] <= 1'b1;
                if (cnt[upd_cidx] != 2'b11) begin
                    cnt[upd_cidx] <= cnt[upd_cidx] + 2'd1;
                end
            end else if (cnt[upd_cidx] != 2'b00) begin
                cnt[upd_cidx] <= cnt[upd_cidx] - 2'd1;
            end
        end
    end

    // Tag/target payload is only meaningful once valid is set, so it carries no reset
    always_ff @(posedge clk) begin
        if (!rst && upd_valid && upd_taken) begin
            tag_mem[u_idx] <= u_tag;
            tgt_mem[u_idx] <= upd_target;
        end
    end

    // Free-running performance counters, wrapping naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookup_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (br_f) begin
                lookup_cnt <= lookup_cnt + CNTW'(1);
            end
            if (mispredict) begin
                mispred_cnt <= mispred_cnt + CNTW'(1);
            end
        end
    end
endmodule

// File: tb/tb_branch_pred_unit.sv
// tb/tb_branch_pred_unit.sv - directed self-checking bench for branch_pred_unit
module tb_branch_pred_unit;
    localparam int AW = 32;
    localparam int EN = 16;
    localparam int CW = 4;
    localparam int IW = 4;

    logic          clk;
    logic          rst;
    logic [AW-1:0] pc_f;
    logic          br_f;
    logic          pred_taken;
    logic [AW-1:0] pred_target;
    logic [IW-1:0] pred_cidx;
    logic          upd_valid;
    logic [AW-1:0] upd_pc;
    logic [IW-1:0] upd_cidx;
    logic          upd_taken;
    logic [AW-1:0] upd_target;
    logic          upd_pred_taken;
    logic          mispredict;
    logic [CW-1:0] lookup_cnt;
    logic [CW-1:0] mispred_cnt;

    int            n_checks;
    int            n_fail;
    logic [CW-1:0] exp_lk;
    logic [CW-1:0] exp_mc;

    branch_pred_unit #(.AWIDTH(AW), .ENTRIES(EN), .CNTW(CW)) dut (
        .clk(clk), .rst(rst), .pc_f(pc_f), .br_f(br_f),
        .pred_taken(pred_taken), .pred_target(pred_target), .pred_cidx(pred_cidx),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_cidx(upd_cidx),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .mispredict(mispredict), .lookup_cnt(lookup_cnt), .mispred_cnt(mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic lookup(input logic b, input logic [AW-1:0] pc);
        br_f = b;
        pc_f = pc;
    endtask

    task automatic upd(input logic v, input logic [AW-1:0] pc, input logic t,
                       input logic [AW-1:0] tgt, input logic pt);
        logic [AW-1:0] p;
        p              = pc;
        upd_valid      = v;
        upd_pc         = pc;
        upd_cidx       = p[5:2];
        upd_taken      = t;
        upd_target     = tgt;
        upd_pred_taken = pt;
    endtask

    // Called ~1ns after inputs change at a negedge; ends at the next negedge
    task automatic step(input logic exp_mp);
        check("mispredict", {63'd0, mispredict}, {63'd0, exp_mp});
        @(posedge clk);
        if (br_f) exp_lk = exp_lk + 1'b1;
        if (exp_mp) exp_mc = exp_mc + 1'b1;
        #1;
        check("lookup_cnt", 64'(lookup_cnt), 64'(exp_lk));
        check("mispred_cnt", 64'(mispred_cnt), 64'(exp_mc));
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_lk   = '0;
        exp_mc   = '0;
        rst      = 1'b1;
        lookup(1'b0, 32'h0);
        upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_pred_taken", {63'd0, pred_taken}, 64'd0);
        check("rst_mispredict", {63'd0, mispredict}, 64'd0);
        check("rst_lookup_cnt", 64'(lookup_cnt), 64'd0);
        check("rst_mispred_cnt", 64'(mispred_cnt), 64'd0);
        @(negedge clk);

`ifdef BPU_GSHARE_EN
        upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b1); #1; step(1'b1);
        upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b1); #1; step(1'b0);
        upd(1'b1, 32'h100, 1'b0, 32'h0,   1'b0); #1; step(1'b0);
        upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        lookup(1'b1, 32'h104); #1;
        check("gshare_cidx_104", 64'(pred_cidx), 64'h7);
        step(1'b0);
        lookup(1'b1, 32'h100); #1;
        check("gshare_cidx_100", 64'(pred_cidx), 64'h6);
        step(1'b0);
`else
        // First lookup after reset
        lookup(1'b1, 32'h100); #1;
        check("first_pred_taken", {63'd0, pred_taken}, 64'd0);
        check("first_pred_cidx", 64'(pred_cidx), 64'd0);
        step(1'b0);

        // Taken update mispredicted; same-cycle lookup sees the old (empty) state
        upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0); #1;
        check("same_cycle_old", {63'd0, pred_taken}, 64'd0);
        step(1'b1);
        upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b1); #1;
        check("after_one_taken", {63'd0, pred_taken}, 64'd1);
        check("after_one_target", 64'(pred_target), 64'h200);
        step(1'b0);
        upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
        check("strong_taken", {63'd0, pred_taken}, 64'd1);
        check("strong_target", 64'(pred_target), 64'h200);
        step(1'b0);

        // Not-taken run: 11 -> 10 -> 01 -> 00 -> 00
        upd(1'b1, 32'h100, 1'b0, 32'h0, 1'b1); #1;
        check("nt1_pred", {63'd0, pred_taken}, 64'd1);
        step(1'b1);
        upd(1'b1, 32'h100, 1'b0, 32'h0, 1'b0); #1;
        check("nt2_old_counter", {63'd0, pred_taken}, 64'd1);
        step(1'b0);
        #1;
        check("nt3_pred", {63'd0, pred_taken}, 64'd0);
        step(1'b0);
        step(1'b0);
        upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
        check("sat_nt_pred", {63'd0, pred_taken}, 64'd0);
        check("sat_nt_target", 64'(pred_target), 64'h200);
        step(1'b0);

        // Entry still valid: correct taken/target update is not a mispredict
        upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b1); #1; step(1'b0);
        #1; step(1'b0);
        #1; step(1'b0);
        upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
        check("retrained_pred", {63'd0, pred_taken}, 64'd1);
        step(1'b0);

        // Alias 0x140 on the same index, different tag
        lookup(1'b1, 32'h140); #1;
        check("alias_cidx", 64'(pred_cidx), 64'd0);
        check("alias_miss", {63'd0, pred_taken}, 64'd0);
        step(1'b0);
        upd(1'b1, 32'h140, 1'b1, 32'h300, 1'b0); #1; step(1'b1);
        upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
        check("alias_hit", {63'd0, pred_taken}, 64'd1);
        check("alias_target", 64'(pred_target), 64'h300);
        step(1'b0);
        lookup(1'b1, 32'h100); #1;
        check("evicted_miss", {63'd0, pred_taken}, 64'd0);
        step(1'b0);

        // Taken and predicted taken, but wrong target
        upd(1'b1, 32'h140, 1'b1, 32'h380, 1'b1); #1; step(1'b1);
        upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        lookup(1'b1, 32'h140); #1;
        check("new_target", 64'(pred_target), 64'h380);
        step(1'b0);
        lookup(1'b0, 32'h140); #1;
        check("no_branch_pred", {63'd0, pred_taken}, 64'd0);
        step(1'b0);

        // Reset in the middle of a pending update
        upd(1'b1, 32'h104, 1'b1, 32'h400, 1'b0);
        #2 rst = 1'b1;
        #1;
        exp_lk = '0;
        exp_mc = '0;
        check("async_lookup_cnt", 64'(lookup_cnt), 64'd0);
        check("async_mispred_cnt", 64'(mispred_cnt), 64'd0);
        @(posedge clk);
        @(negedge clk);
        upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        lookup(1'b1, 32'h140); #1;
        check("post_rst_miss", {63'd0, pred_taken}, 64'd0);
        step(1'b0);
        upd(1'b1, 32'h104, 1'b1, 32'h400, 1'b1); #1;
        step(1'b1);
        upd(1'b1, 32'h108, 1'b1, 32'h500, 1'b0); #1; step(1'b1);
        upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        lookup(1'b1, 32'h108); #1;
        check("rst_counter_weak_nt", {63'd0, pred_taken}, 64'd1);
        check("rst_counter_target", 64'(pred_target), 64'h500);
        step(1'b0);

        // lookup_cnt wraps through all-ones
        for (int i = 0; i < 20; i++) begin
            #1;
            step(1'b0);
        end
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_pred_unit.md
BRANCH_PRED_UNIT -- requirements
Module: branch_pred_unit

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, meaning PC/target width.
REQ-002 SHALL have parameter ENTRIES, default 16, meaning BTB/counter depth, a power of 2 (IDXW = log2(ENTRIES)).
REQ-003 SHALL have parameter CNTW, default 32, meaning width of the performance counters.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 pc_f  input  AWIDTH  fetch PC to look up.
REQ-007 br_f  input  1  fetched instruction is a branch.
REQ-008 pred_taken  output  1  predict taken: br_f, tag hit, valid entry and counter MSB=1.
REQ-009 pred_target  output  AWIDTH  stored target of the looked-up entry.
REQ-010 pred_cidx  output  IDXW  counter index used for this lookup; the pipeline carries it to execute.
REQ-011 upd_valid  input  1  a branch resolved in execute this cycle.
REQ-012 upd_pc  input  AWIDTH  PC of the resolved branch.
REQ-013 upd_cidx  input  IDXW  pred_cidx carried with that branch.
REQ-014 upd_taken  input  1  actual outcome.
REQ-015 upd_target  input  AWIDTH  actual target (ALU result).
REQ-016 upd_pred_taken  input  1  prediction carried with that branch.
REQ-017 mispredict  output  1  combinational: upd_valid & (upd_taken != upd_pred_taken | (upd_taken & upd_pred_taken & target mismatch with stored entry)).
REQ-018 lookup_cnt, mispred_cnt  output  CNTW each  performance counters.

Function
REQ-019 Lookup SHALL be combinational: BTB index = pc_f[IDXW+1:2], tag = pc_f[AWIDTH-1:IDXW+2].
REQ-020 Each entry SHALL hold valid, tag, target and a 2-bit saturating counter (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
REQ-021 On upd_valid, counter[upd_cidx] SHALL increment if upd_taken and decrement otherwise, saturating at 11 and 00.
REQ-022 On upd_valid & upd_taken, BTB entry at upd_pc's index SHALL be written with valid=1, tag and upd_target; allocation replaces any existing entry (direct-mapped).
REQ-023 On upd_valid & !upd_taken, BTB valid/tag/target SHALL remain unchanged.
REQ-024 A lookup and an update in the same cycle to the same index SHALL return the pre-update state; the update becomes visible the next cycle (no bypass).
REQ-025 lookup_cnt SHALL increment each cycle br_f=1; mispred_cnt SHALL increment each cycle mispredict=1; both wrap from all-ones to 0.
REQ-026 pred_taken SHALL be 0 whenever br_f=0, regardless of table state.

Reset
REQ-027 Reset SHALL clear all valid bits, set all counters to 01, and clear lookup_cnt, mispred_cnt and the history register; tags/targets need no reset.
REQ-028 Reset asserted mid-operation SHALL take effect immediately, with no pending update written after release.
REQ-029 After reset, with no updates, pred_taken SHALL read 0 and mispredict SHALL follow only its inputs.

Configuration
REQ-030 Macro BPU_GSHARE_EN SHALL select the counter indexing mode.
REQ-031 With BPU_GSHARE_EN defined: pred_cidx = pc_f[IDXW+1:2] XOR ghr, where ghr is an IDXW-bit global history; on upd_valid, ghr <= {ghr[IDXW-2:0], upd_taken}.
REQ-032 Without BPU_GSHARE_EN: no ghr register; pred_cidx = pc_f[IDXW+1:2].
REQ-033 BTB indexing SHALL be PC-only in both modes.

Verification
REQ-034 After reset, br_f=1, pc_f=0x100 -> pred_taken=0, pred_cidx=0 (non-gshare), lookup_cnt=1 next cycle.
REQ-035 Two taken updates, pc=0x100, target=0x200 -> counter 01->10->11; then lookup 0x100 -> pred_taken=1, pred_target=0x200.
REQ-036 Four not-taken updates on that entry -> counter saturates at 00; the valid entry is retained; pred_taken=0.
REQ-037 Lookup 0x140 (same index as 0x100, different tag, ENTRIES=16) -> pred_taken=0; taken update to 0x140 with target 0x300 replaces it, so 0x100 then misses.
REQ-038 Update with upd_taken=1, upd_pred_taken=0 -> mispredict=1 that cycle and mispred_cnt +1; same-cycle lookup on the same index sees the old counter.
REQ-039 With BPU_GSHARE_EN, taken updates in sequence 1,1,0 -> ghr=4'b0110; lookup pc_f=0x104 -> pred_cidx=4'b0111.
